// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester register-file write arbiter with clear sequencer
//
// Purpose: round-robin arbitration between ALU writeback (A) and load
// writeback (B) onto a single registered write port (5-to-32 decoder address,
// enable and data). A clear request takes over the port for 32 cycles,
// writing zero to every register 0..31.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   clr_req               start the 32-register clear sequence
//   clr_busy              registered, high while the clear sequence runs
//   a_valid/a_addr/a_data requester A handshake inputs, a_ready output
//   b_valid/b_addr/b_data requester B handshake inputs, b_ready output
//   dec_a, dec_en         registered decoder address and enable
//   wr_data               registered write data
//   last_grant            registered, 0 = A granted last, 1 = B granted last

module regfile_wr_arbiter #(
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_req,
  output logic        clr_busy,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic [4:0]  dec_a,
  output logic        dec_en,
  output logic [31:0] wr_data,
  output logic        last_grant
);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        last_grant_q;
  logic        dec_en_q;
  logic [4:0]  dec_a_q;
  logic [31:0] wr_data_q;
  logic        clr_busy_q;

  logic        arb_open;
  logic        grant_a;

  // Ready is only offered in ARB, out of reset, and when no clear is being
  // requested this cycle (the clear takes precedence over any transfer).
  assign arb_open = (state_q == ST_ARB) && rst_n && !clr_req;

  // A wins when it is alone, or on a tie when B was granted last.
  assign grant_a = a_valid && (!b_valid || last_grant_q);

  assign a_ready = arb_open && grant_a;
  assign b_ready = arb_open && b_valid && !grant_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      cnt_q        <= 5'd0;
      last_grant_q <= 1'b1;
      dec_en_q     <= 1'b0;
      dec_a_q      <= 5'd0;
      wr_data_q    <= 32'd0;
      clr_busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (clr_req) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= 5'd0;
            clr_busy_q <= 1'b1;
            dec_en_q   <= 1'b0;
          end else if (a_ready) begin
            dec_a_q      <= a_addr;
            wr_data_q    <= a_data;
            // Writes to r0 complete the handshake but never reach the array.
            dec_en_q     <= !((ZERO_REG == 1) && (a_addr == 5'd0));
            last_grant_q <= 1'b0;
          end else if (b_ready) begin
            dec_a_q      <= b_addr;
            wr_data_q    <= b_data;
            dec_en_q     <= !((ZERO_REG == 1) && (b_addr == 5'd0));
            last_grant_q <= 1'b1;
          end else begin
            dec_en_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          // The clear writes r0 as well, regardless of ZERO_REG.
          dec_en_q  <= 1'b1;
          dec_a_q   <= cnt_q;
          wr_data_q <= 32'd0;
          cnt_q     <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q    <= ST_ARB;
            clr_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_ARB;
          dec_en_q   <= 1'b0;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign dec_en     = dec_en_q;
  assign dec_a      = dec_a_q;
  assign wr_data    = wr_data_q;
  assign last_grant = last_grant_q;
  assign clr_busy   = clr_busy_q;

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have parameter ZERO_REG, default 1; when 1, writes to address 0 are accepted but never produce a decoder enable.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-004 The block SHALL have port clr_req, input, 1, a request to start the 32-register clear sequence.
REQ-005 The block SHALL have port clr_busy, output, 1, high while the clear sequence runs.
REQ-006 The block SHALL have ports a_valid, input, 1; a_addr, input, 5; a_data, input, 32; and a_ready, output, 1, forming requester A (ALU writeback).
REQ-007 The block SHALL have ports b_valid, input, 1; b_addr, input, 5; b_data, input, 32; and b_ready, output, 1, forming requester B (load writeback).
REQ-008 The block SHALL have port dec_a, output, 5, the registered address to the 5-to-32 write decoder.
REQ-009 The block SHALL have port dec_en, output, 1, the registered decoder enable.
REQ-010 The block SHALL have port wr_data, output, 32, the registered register-file write data.
REQ-011 The block SHALL have port last_grant, output, 1, registered: 0 = A granted last, 1 = B granted last.

Function
REQ-012 The block SHALL have two states: ARB and CLEAR.
REQ-013 A transfer SHALL occur on any rising edge where x_valid and x_ready are both high.
REQ-014 In ARB, ready SHALL be combinational: at most one of a_ready/b_ready is high, and both are low when clr_req is high.
REQ-015 Round-robin, only A valid: A SHALL be granted.
REQ-016 Round-robin, only B valid: B SHALL be granted.
REQ-017 Round-robin, both valid: the requester not equal to last_grant SHALL be granted.
REQ-018 last_grant SHALL update only on a transfer.
REQ-019 A ready SHALL be raised only when its valid is high; a_ready=a_valid&&grantA.
REQ-020 Latency SHALL be 1 cycle: the edge after a transfer drives dec_a=addr, wr_data=data, and dec_en=1.
REQ-021 Exception to REQ-020: if ZERO_REG=1 and addr==0, the transfer SHALL complete but dec_en SHALL be 0.
REQ-022 In a cycle with no transfer in ARB, the block SHALL drive dec_en=0 while dec_a and wr_data hold their last values.
REQ-023 If clr_req is high in ARB, the block SHALL enter CLEAR on that edge with counter=0 and no transfer.
REQ-024 In CLEAR, each cycle SHALL register dec_en=1, dec_a=counter, and wr_data=0, then increment the counter.
REQ-025 The clear SHALL cover addresses 0..31, including 0, regardless of ZERO_REG, for 32 enabled cycles total.
REQ-026 After the edge issuing address 31, the block SHALL return to ARB; the counter wraps to 0.
REQ-027 In CLEAR, a_ready=b_ready=0 and clr_busy=1 SHALL hold; clr_req SHALL be ignored there.
REQ-028 clr_busy SHALL be registered: it goes high on the edge entering CLEAR and low on the edge returning to ARB.
REQ-029 Valid held low by a requester SHALL never be granted; the block SHALL NOT store requests, and a requester holds valid/addr/data until ready.
REQ-030 Requests arriving during CLEAR SHALL be served, in round-robin order, starting the cycle after return to ARB.

Reset
REQ-031 When rst_n=0 at an edge, the block SHALL set: state=ARB, counter=0, last_grant=1 (A wins first tie), dec_en=0, dec_a=0, wr_data=0, clr_busy=0.
REQ-032 Reset mid-CLEAR SHALL abort the sequence with no further enabled writes; resumption SHALL require a new clr_req.
REQ-033 While rst_n=0, a_ready and b_ready SHALL be 0.

Verification
REQ-034 The bench SHALL cover: reset release, a_valid=1, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 that cycle; next cycle dec_en=1, dec_a=5, wr_data=0xDEADBEEF, last_grant=0.
REQ-035 The bench SHALL cover: A and B both valid for 4 cycles (A addr 1, B addr 2) -> grants A,B,A,B; dec_a sequence 1,2,1,2 one cycle later.
REQ-036 The bench SHALL cover: ZERO_REG=1, B valid, addr 0 -> b_ready=1, transfer completes, dec_en=0 the next cycle.
REQ-037 The bench SHALL cover: one clr_req pulse with A valid -> no A grant; clr_busy=1 for 32 cycles; dec_a steps 0..31 with dec_en=1 and wr_data=0; A granted the first ARB cycle after.
REQ-038 The bench SHALL cover: rst_n=0 at clear step 10 -> next cycle dec_en=0, clr_busy=0, state ARB; no address 11 write follows.
REQ-039 The bench SHALL cover: B valid alone twice, then A and B valid together -> B, B, then A is granted (last_grant=1).
